// File: rtl/alu_md_control_pkg.sv
// Shared constants for the ALU control decoder and the multiply/divide sequencer:
// ALUOp values, funct fields, ALU control codes and the sequencer state type.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_FIX  = 2'b11
    } md_state_t;

    // MD opcodes occupy funct 0100xx (HI/LO moves) and 0110xx (mult/div).
    function automatic logic is_md_funct(input logic [5:0] f);
        return (f[5:2] == 4'b0100) || (f[5:2] == 4'b0110);
    endfunction

    function automatic logic is_muldiv_funct(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/alu_md_control_if.sv
// Bus between the main control / register read stage and the ALU control block.
interface alu_md_control_if #(
    parameter int DATA_W   = 32,
    parameter int ALUCTL_W = 4
) ();
    logic                valid_in;
    logic [1:0]          alu_op;
    logic [5:0]          funct;
    logic [DATA_W-1:0]   opnd_a;
    logic [DATA_W-1:0]   opnd_b;
    logic [ALUCTL_W-1:0] alu_ctl;
    logic                stall;
    logic                md_busy;
    logic                md_done;
    logic                hilo_rd_en;
    logic [DATA_W-1:0]   hilo_rd;

    modport master (
        output valid_in, alu_op, funct, opnd_a, opnd_b,
        input  alu_ctl, stall, md_busy, md_done, hilo_rd_en, hilo_rd
    );

    modport slave (
        input  valid_in, alu_op, funct, opnd_a, opnd_b,
        output alu_ctl, stall, md_busy, md_done, hilo_rd_en, hilo_rd
    );
endinterface

// File: rtl/alu_md_control_md_seq.sv
// Iterative multiply/divide sequencer: shift-add multiply, restoring divide,
// sign fix-up on magnitudes, and the HI/LO register pair.
module md_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_is_div,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_opnd_a,
    input  logic [DATA_W-1:0] i_opnd_b,
    input  logic              i_wr_hi,
    input  logic              i_wr_lo,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);
    localparam int CNT_W = $clog2(DATA_W);

    md_state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]     r_opnd_b, r_hi, r_lo;
    logic                  r_is_div, r_neg_q, r_neg_r, r_dz;

    logic                  w_sign_a, w_sign_b, w_dz;
    logic [DATA_W:0]       w_mul_sum, w_rem_sh, w_rem_sub;
    logic [2*DATA_W-1:0]   w_mul_nxt, w_div_nxt, w_prod;
    logic [DATA_W-1:0]     w_fix_hi, w_fix_lo;

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? -v : v;
    endfunction

    function automatic logic [DATA_W-1:0] cneg(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] cneg2(input logic [2*DATA_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign w_sign_a = i_signed & i_opnd_a[DATA_W-1];
    assign w_sign_b = i_signed & i_opnd_b[DATA_W-1];
    assign w_dz     = i_is_div & (i_opnd_b == '0);

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign w_mul_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_opnd_b} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[DATA_W-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
    assign w_rem_sh  = r_acc[2*DATA_W-1:DATA_W-1];
    assign w_rem_sub = w_rem_sh - {1'b0, r_opnd_b};
    assign w_div_nxt = w_rem_sub[DATA_W]
                     ? {w_rem_sh[DATA_W-1:0],  r_acc[DATA_W-2:0], 1'b0}
                     : {w_rem_sub[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};

    assign w_prod   = cneg2(r_acc, r_neg_q);
    assign w_fix_hi = r_dz     ? r_acc[2*DATA_W-1:DATA_W]
                    : r_is_div ? cneg(r_acc[2*DATA_W-1:DATA_W], r_neg_r)
                    :            w_prod[2*DATA_W-1:DATA_W];
    assign w_fix_lo = r_dz     ? r_acc[DATA_W-1:0]
                    : r_is_div ? cneg(r_acc[DATA_W-1:0], r_neg_q)
                    :            w_prod[DATA_W-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= MD_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        case (r_state)
            MD_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_state_nxt = w_dz ? MD_FIX : (i_is_div ? MD_DIV : MD_MUL);
            end
            MD_MUL, MD_DIV: if (r_cnt == '0) w_state_nxt = MD_FIX;
            MD_FIX: begin
                o_done      = 1'b1;
                w_state_nxt = MD_IDLE;
            end
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd_b <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: if (i_start) begin
                    r_opnd_b <= mag(i_opnd_b, i_signed);
                    r_is_div <= i_is_div;
                    r_dz     <= w_dz;
                    r_neg_q  <= w_sign_a ^ w_sign_b;
                    r_neg_r  <= w_sign_a;
                    r_cnt    <= CNT_W'(DATA_W-1);
                    r_acc    <= w_dz ? {i_opnd_a, {DATA_W{1'b1}}}
                                     : {{DATA_W{1'b0}}, mag(i_opnd_a, i_signed)};
                end
                MD_MUL: begin
                    r_acc <= w_mul_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                MD_DIV: begin
                    r_acc <= w_div_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                MD_FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
            // Moves only happen while idle, so they never collide with the FIX write.
            if (i_wr_hi) r_hi <= i_wr_data;
            if (i_wr_lo) r_lo <= i_wr_data;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/alu_md_control.sv
// ALU control decoder with pipeline stall logic and an optional output register;
// multi-cycle multiply/divide and HI/LO live in md_seq.
module alu_md_control
    import alu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ALUCTL_W = 4,
    parameter int REG_CTL  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_md_control_if.slave bus
);
    logic                w_rtype, w_md, w_muldiv, w_stall, w_go, w_busy;
    logic [ALUCTL_W-1:0] w_ctl_dec;
    logic [DATA_W-1:0]   w_hi, w_lo;

    function automatic logic [3:0] decode(input logic [1:0] op, input logic [5:0] f);
        logic [3:0] c;
        c = ALU_ADD;
        case (op)
            ALUOP_SUB: c = ALU_SUB;
            ALUOP_SLT: c = ALU_SLT;
            ALUOP_RTYPE: begin
                case (f)
                    F_ADD, F_ADDU: c = ALU_ADD;
                    F_SUB, F_SUBU: c = ALU_SUB;
                    F_AND:         c = ALU_AND;
                    F_OR:          c = ALU_OR;
                    F_XOR:         c = ALU_XOR;
                    F_NOR:         c = ALU_NOR;
                    F_SLT:         c = ALU_SLT;
                    F_SLTU:        c = ALU_SLTU;
                    F_SLL:         c = ALU_SLL;
                    F_SRL:         c = ALU_SRL;
                    F_SRA:         c = ALU_SRA;
                    default:       c = ALU_ADD;
                endcase
            end
            default: c = ALU_ADD;
        endcase
        return c;
    endfunction

    assign w_ctl_dec = decode(bus.alu_op, bus.funct);
    assign w_rtype   = bus.alu_op == ALUOP_RTYPE;
    assign w_md      = w_rtype & is_md_funct(bus.funct);
    assign w_muldiv  = w_rtype & is_muldiv_funct(bus.funct);
    // An MD op seen while the sequencer is busy is held in EX until it drains.
    assign w_stall   = bus.valid_in & w_busy & w_md;
    assign w_go      = bus.valid_in & w_rtype & ~w_stall;

    md_seq #(.DATA_W(DATA_W)) u_md_seq (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (w_go & w_muldiv),
        .i_is_div  (bus.funct[1]),
        .i_signed  (~bus.funct[0]),
        .i_opnd_a  (bus.opnd_a),
        .i_opnd_b  (bus.opnd_b),
        .i_wr_hi   (w_go & (bus.funct == F_MTHI)),
        .i_wr_lo   (w_go & (bus.funct == F_MTLO)),
        .i_wr_data (bus.opnd_a),
        .o_busy    (w_busy),
        .o_done    (bus.md_done),
        .o_hi      (w_hi),
        .o_lo      (w_lo)
    );

    assign bus.stall      = w_stall;
    assign bus.md_busy    = w_busy;
    assign bus.hilo_rd_en = w_go & ((bus.funct == F_MFHI) | (bus.funct == F_MFLO));
    assign bus.hilo_rd    = bus.funct[1] ? w_lo : w_hi;

    generate
        if (REG_CTL != 0) begin : g_reg_ctl
            logic [ALUCTL_W-1:0] r_alu_ctl;
            always_ff @(posedge clk) begin
                if (!rst_n)        r_alu_ctl <= ALU_ADD;
                else if (!w_stall) r_alu_ctl <= w_ctl_dec;
            end
            assign bus.alu_ctl = r_alu_ctl;
        end else begin : g_comb_ctl
            assign bus.alu_ctl = w_ctl_dec;
        end
    endgenerate

endmodule

// File: tb/tb_alu_md_control.sv
// Directed bench: REG_CTL=0 instance for decode and multiply/divide, REG_CTL=1
// instance for the registered control code; HI/LO expectations via a queue.
module tb_alu_md_control;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_md_control_if #(.DATA_W(W), .ALUCTL_W(4)) if0 ();
    alu_md_control_if #(.DATA_W(W), .ALUCTL_W(4)) if1 ();

    alu_md_control #(.DATA_W(W), .ALUCTL_W(4), .REG_CTL(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    alu_md_control #(.DATA_W(W), .ALUCTL_W(4), .REG_CTL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    int n_tests = 0;
    int n_fail  = 0;
    int done0   = 0;
    logic [W-1:0] exp_q[$];

    // {alu_op, funct, expected alu_ctl}
    localparam logic [11:0] DEC_TAB [16] = '{
        {2'b00, 6'b000000, 4'b0010}, {2'b01, 6'b000000, 4'b0110}, {2'b11, 6'b000000, 4'b0111},
        {2'b10, 6'b100000, 4'b0010}, {2'b10, 6'b100011, 4'b0110}, {2'b10, 6'b100100, 4'b0000},
        {2'b10, 6'b100101, 4'b0001}, {2'b10, 6'b100110, 4'b0011}, {2'b10, 6'b100111, 4'b1100},
        {2'b10, 6'b101010, 4'b0111}, {2'b10, 6'b101011, 4'b1000}, {2'b10, 6'b000000, 4'b1001},
        {2'b10, 6'b000010, 4'b1010}, {2'b10, 6'b000011, 4'b1011}, {2'b10, 6'b111111, 4'b0010},
        {2'b10, 6'b011010, 4'b0010}
    };

    always @(posedge clk) if (if0.md_done === 1'b1) done0 <= done0 + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic [1:0] op, input logic [5:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        if0.valid_in = v; if0.alu_op = op; if0.funct = f; if0.opnd_a = a; if0.opnd_b = b;
    endtask

    task automatic drv1(input logic v, input logic [1:0] op, input logic [5:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        if1.valid_in = v; if1.alu_op = op; if1.funct = f; if1.opnd_a = a; if1.opnd_b = b;
    endtask

    // Reference results from 64-bit integer arithmetic; pushes HI then LO.
    task automatic push_exp(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        longint la, lb, q, r;
        logic [63:0] p;
        logic [W-1:0] hi, lo;
        hi = '0; lo = '0;
        case (f)
            F_MULT: begin
                la = longint'($signed(a)); lb = longint'($signed(b)); p = la * lb;
                hi = p[63:32]; lo = p[31:0];
            end
            F_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                hi = p[63:32]; lo = p[31:0];
            end
            default: begin
                if (f == F_DIV) begin la = longint'($signed(a)); lb = longint'($signed(b)); end
                else begin la = longint'({32'b0, a}); lb = longint'({32'b0, b}); end
                if (b == '0) begin hi = a; lo = '1; end
                else begin q = la / lb; r = la % lb; hi = r[31:0]; lo = q[31:0]; end
            end
        endcase
        exp_q.push_back(hi);
        exp_q.push_back(lo);
    endtask

    task automatic read_hilo(input string tag);
        drv0(1'b1, ALUOP_RTYPE, F_MFHI, '0, '0);
        @(negedge clk);
        chk({tag, " mfhi_en"}, if0.hilo_rd_en, 1);
        chk({tag, " hi"}, if0.hilo_rd, exp_q.pop_front());
        step();
        drv0(1'b1, ALUOP_RTYPE, F_MFLO, '0, '0);
        @(negedge clk);
        chk({tag, " lo"}, if0.hilo_rd, exp_q.pop_front());
        step();
        drv0(1'b0, ALUOP_ADD, '0, '0, '0);
    endtask

    task automatic run_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_busy, input string tag);
        int busy, dn;
        push_exp(f, a, b);
        drv0(1'b1, ALUOP_RTYPE, f, a, b);
        @(negedge clk);
        chk({tag, " accept_stall"}, if0.stall, 0);
        step();
        drv0(1'b0, ALUOP_ADD, '0, '0, '0);
        busy = 0; dn = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if0.md_done === 1'b1) dn++;
            if (if0.md_busy !== 1'b1) break;
            busy++;
        end
        chk({tag, " busy_cycles"}, busy, exp_busy);
        chk({tag, " done_pulses"}, dn, 1);
        step();
        read_hilo(tag);
    endtask

    initial begin
        int st, leak, bad, d0;
        logic [W-1:0] e_hi, e_lo;

        drv0(1'b0, ALUOP_ADD, '0, '0, '0);
        drv1(1'b0, ALUOP_ADD, '0, '0, '0);
        rst_n = 1'b0;
        step(); step();
        @(negedge clk);
        chk("rst md_busy", if0.md_busy, 0);
        chk("rst md_done", if0.md_done, 0);
        chk("rst stall", if0.stall, 0);
        chk("rst hilo_rd_en", if0.hilo_rd_en, 0);
        chk("rst regctl", if1.alu_ctl, 4'b0010);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drv0(1'b0, DEC_TAB[i][11:10], DEC_TAB[i][9:4], '0, '0);
            @(negedge clk);
            chk($sformatf("decode[%0d]", i), if0.alu_ctl, DEC_TAB[i][3:0]);
            step();
        end

        run_md(F_MULTU, 32'hFFFF_FFFF, 32'd2, 33, "multu");
        run_md(F_MULT, 32'hFFFF_FFFD, 32'd5, 33, "mult");
        run_md(F_DIVU, 32'h0000_1234, 32'd0, 1, "divu0");
        run_md(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, "divovf");
        run_md(F_DIVU, 32'd100, 32'd7, 33, "divu");
        run_md(F_DIV, 32'd7, 32'hFFFF_FFFE, 33, "div7");

        // Signed divide with mflo right behind it: held until the result lands.
        push_exp(F_DIV, 32'hFFFF_FFF9, 32'd2);
        e_hi = exp_q.pop_front();
        e_lo = exp_q.pop_front();
        drv0(1'b1, ALUOP_RTYPE, F_DIV, 32'hFFFF_FFF9, 32'd2);
        step();
        drv0(1'b1, ALUOP_RTYPE, F_MFLO, '0, '0);
        st = 0; leak = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if0.stall !== 1'b1) break;
            if (if0.hilo_rd_en === 1'b1) leak++;
            st++;
        end
        chk("sdiv stall_cycles", st, 33);
        chk("sdiv rd_en_during_stall", leak, 0);
        chk("sdiv mflo_en", if0.hilo_rd_en, 1);
        chk("sdiv mflo", if0.hilo_rd, e_lo);
        step();
        drv0(1'b1, ALUOP_RTYPE, F_MFHI, '0, '0);
        @(negedge clk);
        chk("sdiv mfhi", if0.hilo_rd, e_hi);
        step();

        drv0(1'b1, ALUOP_RTYPE, F_MTLO, 32'h5A5A_1234, '0);
        step();
        drv0(1'b1, ALUOP_RTYPE, F_MFLO, '0, '0);
        @(negedge clk);
        chk("mtlo readback", if0.hilo_rd, 32'h5A5A_1234);
        step();
        drv0(1'b0, ALUOP_ADD, '0, '0, '0);

        // Registered alu_ctl: one cycle late, frozen during a stall.
        drv1(1'b0, ALUOP_RTYPE, F_AND, '0, '0);
        @(negedge clk);
        chk("regctl before_edge", if1.alu_ctl, 4'b0010);
        step();
        @(negedge clk);
        chk("regctl after_edge", if1.alu_ctl, 4'b0000);
        exp_q.push_back(32'd42);
        drv1(1'b1, ALUOP_RTYPE, F_MULT, 32'd6, 32'd7);
        step();
        drv1(1'b1, ALUOP_RTYPE, F_OR, '0, '0);
        step();
        drv1(1'b1, ALUOP_RTYPE, F_MFLO, '0, '0);
        st = 0; bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if1.stall !== 1'b1) break;
            if (if1.alu_ctl !== 4'b0001) bad++;
            st++;
        end
        chk("regctl stall_cycles", st, 32);
        chk("regctl frozen_bad_cycles", bad, 0);
        chk("regctl held_after_stall", if1.alu_ctl, 4'b0001);
        chk("regctl mflo", if1.hilo_rd, exp_q.pop_front());
        step();
        @(negedge clk);
        chk("regctl resumes", if1.alu_ctl, 4'b0010);
        drv1(1'b1, ALUOP_RTYPE, F_MTHI, 32'hA5A5_A5A5, '0);
        step();
        drv1(1'b1, ALUOP_RTYPE, F_MFHI, '0, '0);
        @(negedge clk);
        chk("regctl mfhi_en", if1.hilo_rd_en, 1);
        chk("regctl mthi_readback", if1.hilo_rd, 32'hA5A5_A5A5);
        step();
        drv1(1'b0, ALUOP_ADD, '0, '0, '0);

        // Reset ten cycles into a multiply: operation lost, HI/LO cleared.
        d0 = done0;
        drv0(1'b1, ALUOP_RTYPE, F_MULT, 32'h1234_5678, 32'd9);
        step();
        drv0(1'b0, ALUOP_ADD, '0, '0, '0);
        repeat (10) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid md_busy", if0.md_busy, 0);
        chk("rstmid md_done", if0.md_done, 0);
        repeat (40) step();
        chk("rstmid no_done_pulse", done0, d0);
        exp_q.push_back('0);
        exp_q.push_back('0);
        read_hilo("rstmid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_md_control.md
Name: alu_md_control

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Decodes ALUOp/funct into an extended ALU control code covering shifts, xor, nor and sltu.
- Adds an iterative multiply/divide sequencer with HI/LO registers, busy/stall handshake and mfhi/mflo/mthi/mtlo support.
- Sits between the main control unit and the EX stage; drives the ALU and stalls the pipeline during multi-cycle operations.

Parameters:
- DATA_W, 32: operand, HI and LO width; must be ≥ 4.
- ALUCTL_W, 4: width of alu_ctl; fixed at 4 for the encodings below.
- REG_CTL, 0: 0 = alu_ctl combinational (0-cycle latency); 1 = alu_ctl registered (1-cycle latency).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- valid_in  in  1  instruction in EX is valid.
- alu_op  in  2  ALUOp from main control.
- funct  in  6  instruction funct field.
- opnd_a  in  DATA_W  rs value; dividend / multiplicand.
- opnd_b  in  DATA_W  rt value; divisor / multiplier.
- alu_ctl  out  ALUCTL_W  ALU operation code.
- stall  out  1  hold the pipeline this cycle.
- md_busy  out  1  sequencer is not IDLE.
- md_done  out  1  one-cycle pulse when HI/LO are updated.
- hilo_rd_en  out  1  mfhi/mflo result valid this cycle.
- hilo_rd  out  DATA_W  selected HI or LO value.

Behaviour:
- **Decode** (combinational when REG_CTL=0):
  - alu_op 00 → 0010 (add); 01 → 0110 (sub); 11 → 0111 (slt, used for slti).
  - alu_op 10, by funct: 100000/100001 → 0010; 100010/100011 → 0110; 100100 → 0000; 100101 → 0001; 100110 → 0011; 100111 → 1100; 101010 → 0111; 101011 → 1000; 000000 → 1001 (sll); 000010 → 1010 (srl); 000011 → 1011 (sra).
  - Any other funct → 0010.
- **REG_CTL=1:** alu_ctl is registered; it resets to 0010 and holds its value while stall=1.
- **MD opcodes** (alu_op=10 only): mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
- **State machine:** IDLE, MUL, DIV, FIX.
  - IDLE → MUL/DIV on valid_in with a mult*/div* funct.
    - Capture the operands; take magnitudes for signed ops.
    - Record the result signs (product sign = a^b; quotient sign = a^b; remainder sign = sign of a).
    - Load count = DATA_W-1.
  - MUL: one shift-add step per cycle on a 2·DATA_W accumulator; leave for FIX when count = 0 (DATA_W cycles).
  - DIV: one restoring step per cycle; leave for FIX after DATA_W cycles.
  - FIX: apply two's-complement sign correction, write HI/LO, pulse md_done, go to IDLE.
  - Total busy: DATA_W+1 cycles from the accept edge; HI/LO are visible the cycle after FIX.
- **Divide by zero:** go IDLE → FIX directly (2 cycles total); HI = opnd_a, LO = all ones. No exception is raised.
- **Signed edge case:** signed div of most-negative by -1 gives LO = most-negative, HI = 0 (wraps, no trap).
- **stall** = valid_in & md_busy & (funct is any MD opcode) & alu_op==10.
  - An MD op arriving while busy is held and never dropped.
  - Non-MD instructions do not stall.
- **mfhi/mflo:** when not stalled, hilo_rd_en=1 in the same cycle and hilo_rd = HI or LO (combinational).
- **mthi/mtlo:** when not stalled, HI or LO ← opnd_a at the clock edge.
- **Simultaneity:** FIX write and mthi/mtlo cannot coincide, since mthi/mtlo stalls while busy.
- **Reset:** while rst_n=0 at an edge, the FSM → IDLE and HI, LO, count and accumulator → 0, including mid-operation; the in-flight op is lost. Outputs after reset: md_busy=0, md_done=0, stall=0, hilo_rd_en=0.
- **valid_in=0:** no state change and no stall; alu_ctl still decodes.

Decomposition:
- Shared package alu_pkg holds:
  - ALUOp constants;
  - funct constants (R-type and MD);
  - ALU control codes (ALU_ADD=0010 … ALU_SRA=1011);
  - the md_state_t enum.
- One sub-module, md_seq: the iterative multiply/divide datapath plus its FSM, HI/LO and sign fix.
- The top-level alu_md_control keeps the decode, stall logic and the REG_CTL register.

Test Plan:
- **Full decode sweep (REG_CTL=0):** alu_op 10, funct 100111 → alu_ctl 1100; funct 000011 → 1011; funct 111111 → 0010; alu_op 11 → 0111.
- **multu (DATA_W=32):** a=0xFFFFFFFF, b=2 → md_busy for 33 cycles, md_done once; then mfhi reads 0x00000001 and mflo 0xFFFFFFFE.
- **Signed div:** a=-7, b=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Issue mflo the cycle after accept → stall=1 until FIX completes, then hilo_rd=0xFFFFFFFD.
- **Divide by zero:** divu a=0x1234, b=0 → md_done on the 2nd cycle; HI=0x1234, LO=0xFFFFFFFF.
- **Reset mid-op:** drop rst_n 10 cycles into a mult → next cycle md_busy=0, HI=LO=0, no md_done pulse.
- **REG_CTL=1 with stall:** alu_ctl updates one cycle after funct changes and stays frozen while stall=1; mthi 0xA5A5A5A5 then mfhi returns 0xA5A5A5A5.
